// File: rtl/mem_pkg.sv
// mem_pkg: shared op/size/state encodings and lane-mask helpers for the memory stage
package mem_pkg;
  typedef enum logic [1:0] {MEM_ALU, MEM_LOAD, MEM_STORE, MEM_NOP} mem_op_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
  function automatic logic [2:0] size_mask(input size_e s);
    return s == SZ_B ? 3'b000 : s == SZ_H ? 3'b001 : s == SZ_W ? 3'b011 : 3'b111;
  endfunction
  function automatic logic [7:0] size_strb(input size_e s);
    return s == SZ_B ? 8'h01 : s == SZ_H ? 8'h03 : s == SZ_W ? 8'h0f : 8'hff;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: select the addressed lane of a load word and sign/zero-extend it to 64 bits
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  off,
  input  size_e       size,
  input  logic        uns,
  output logic [63:0] res
);
  logic [63:0] lane;
  logic        sx;
  always_comb begin
    lane = word >> {off, 3'b000};
    sx   = !uns;
    res  = size == SZ_B ? {{56{sx & lane[7]}}, lane[7:0]}
         : size == SZ_H ? {{48{sx & lane[15]}}, lane[15:0]}
         : size == SZ_W ? {{32{sx & lane[31]}}, lane[31:0]}
         : lane;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory/writeback stage turning execute results into writebacks and valid/ready data-memory requests
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [1:0]        ex_op,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [4:0]        ex_dest,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic              dmem_req_we,
  output logic [DATA_W-1:0] dmem_req_wdata,
  output logic [7:0]        dmem_req_wstrb,
  input  logic              dmem_resp_valid,
  input  logic [DATA_W-1:0] dmem_resp_data,
  output logic              wb_en,
  output logic [4:0]        wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign
);
  state_e            state;
  mem_op_e           op_q;
  size_e             size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [4:0]        dest_q;
  mem_op_e           op_in;
  logic              mis;
  logic [63:0]       ld_data;
  always_comb begin
    op_in = mem_op_e'(ex_op);
    mis   = |(ex_addr[2:0] & size_mask(size_e'(ex_size)));
  end
  assign ex_ready       = state == S_IDLE;
  assign dmem_req_valid = state == S_REQ;
  assign dmem_req_we    = dmem_req_valid && op_q == MEM_STORE;
  assign dmem_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign dmem_req_wstrb = dmem_req_we ? size_strb(size_q) << addr_q[2:0] : '0;
  assign dmem_req_wdata = dmem_req_we ? data_q << {addr_q[2:0], 3'b000} : '0;
  load_align u_align (
    .word (dmem_resp_data),
    .off  (addr_q[2:0]),
    .size (size_q),
    .uns  (uns_q),
    .res  (ld_data)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= MEM_ALU;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      dest_q   <= '0;
      wb_en    <= 1'b0;
      wb_dest  <= '0;
      wb_data  <= '0;
      misalign <= 1'b0;
    end else begin
      wb_en    <= 1'b0;
      misalign <= 1'b0;
      case (state)
        S_IDLE: if (ex_valid) begin
          op_q   <= op_in;
          size_q <= size_e'(ex_size);
          uns_q  <= ex_unsigned;
          addr_q <= ex_addr;
          data_q <= ex_data;
          dest_q <= ex_dest;
          if (op_in == MEM_ALU) begin
            wb_en   <= ex_dest != 5'd0;
            wb_dest <= ex_dest;
            wb_data <= ex_data;
          end else if (op_in != MEM_NOP) begin
            if (mis) misalign <= 1'b1;
            else state <= S_REQ;
          end
        end
        S_REQ: if (dmem_req_ready) state <= op_q == MEM_STORE ? S_IDLE : S_WAIT;
        S_WAIT: if (dmem_resp_valid) begin
          wb_en   <= dest_q != 5'd0;
          wb_dest <= dest_q;
          wb_data <= ld_data;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
